// File: rtl/inst_dispatch_queue_pkg.sv
// Shared definitions for the instruction dispatch queue: opcodes, FSM states
// and the instruction word field layout (opcode | addr | length | port | reserved).
package inst_dispatch_queue_pkg;

   localparam int         OP_WIDTH = 3;
   localparam logic [2:0] OP_XFER  = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_EXEC = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

   function automatic int port_width(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   function automatic int op_lsb(input int iw);
      return iw - OP_WIDTH;
   endfunction

   function automatic int addr_lsb(input int iw, input int aw);
      return op_lsb(iw) - aw;
   endfunction

   function automatic int len_lsb(input int iw, input int aw, input int lw);
      return addr_lsb(iw, aw) - lw;
   endfunction

   function automatic int port_lsb(input int iw, input int aw, input int lw, input int np);
      return len_lsb(iw, aw, lw) - port_width(np);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
// Push on full and pop on empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/inst_dispatch_queue.sv
// Instruction dispatch queue: buffers instruction words and dispatches them either
// as memory transfer bursts (opcode 000) or as issues to an external compute engine.
module inst_dispatch_queue
   import inst_dispatch_queue_pkg::*;
#(
   parameter int INST_WIDTH = 28,
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 6,
   parameter int NUM_PORTS  = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [INST_WIDTH-1:0]         inst,
   input  logic                          inst_valid,
   output logic                          inst_ready,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [NUM_PORTS-1:0]          mem_port,
   output logic                          mem_valid,
   input  logic                          mem_ready,
   output logic [INST_WIDTH-1:0]         exec_inst,
   output logic                          exec_valid,
   input  logic                          exec_done,
   output logic                          busy,
   output logic                          retire,
   output logic                          err,
   output logic [$clog2(FIFO_DEPTH):0]   fill_count,
   output state_e                        dbg_state
);

   localparam int PW       = port_width(NUM_PORTS);
   localparam int CW       = $clog2(FIFO_DEPTH) + 1;
   localparam int OP_LSB   = op_lsb(INST_WIDTH);
   localparam int ADDR_LSB = addr_lsb(INST_WIDTH, ADDR_WIDTH);
   localparam int LEN_LSB  = len_lsb(INST_WIDTH, ADDR_WIDTH, LEN_WIDTH);
   localparam int PORT_LSB = port_lsb(INST_WIDTH, ADDR_WIDTH, LEN_WIDTH, NUM_PORTS);
   localparam logic [PW:0] NUM_PORTS_V = (PW+1)'(NUM_PORTS);

   // Handshakes (valid/ready): a transfer happens on a rising edge where both are
   // high; a source holds its payload stable while valid is high and ready is low.

   logic                  fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [INST_WIDTH-1:0] head;
   logic [CW-1:0]         count;

   state_e                state_q;
   logic                  ready_q;
   logic                  mem_valid_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [NUM_PORTS-1:0]  mem_port_q;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d, len_q;
   logic                  exec_valid_q;
   logic [INST_WIDTH-1:0] exec_inst_q;
   logic                  retire_q;
   logic                  err_q;

   logic [2:0]            head_op;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [LEN_WIDTH-1:0]  head_len;
   logic [PW-1:0]         head_port;
   logic                  head_port_ok;
   logic [NUM_PORTS-1:0]  head_onehot;
   logic                  last_beat;

   assign inst_ready = ready_q & ~fifo_full;
   assign fifo_push  = inst_valid & inst_ready;
   assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty;

   sync_fifo #(
      .WIDTH (INST_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (fifo_push),
      .data_i  (inst),
      .pop_i   (fifo_pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count)
   );

   assign head_op      = head[OP_LSB +: 3];
   assign head_addr    = head[ADDR_LSB +: ADDR_WIDTH];
   assign head_len     = head[LEN_LSB +: LEN_WIDTH];
   assign head_port    = head[PORT_LSB +: PW];
   assign head_port_ok = ({1'b0, head_port} < NUM_PORTS_V);
   assign head_onehot  = NUM_PORTS'(1) << head_port;

   assign beat_d     = beat_q + LEN_WIDTH'(1);
   assign mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
   assign last_beat  = (beat_d == len_q);

   // Dropped and zero-length instructions never leave IDLE; their retire pulse
   // lands in the cycle after the pop, which is itself a cycle that may pop again.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         ready_q      <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_port_q   <= '0;
         beat_q       <= '0;
         len_q        <= '0;
         exec_valid_q <= 1'b0;
         exec_inst_q  <= '0;
         retire_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         ready_q      <= 1'b1;
         retire_q     <= 1'b0;
         exec_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  if (!head_port_ok) begin
                     err_q    <= 1'b1;
                     retire_q <= 1'b1;
                  end else if (head_op == OP_XFER) begin
                     if (head_len == '0) begin
                        retire_q <= 1'b1;
                     end else begin
                        state_q     <= ST_XFER;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= head_addr;
                        mem_port_q  <= head_onehot;
                        beat_q      <= '0;
                        len_q       <= head_len;
                     end
                  end else begin
                     state_q      <= ST_EXEC;
                     exec_valid_q <= 1'b1;
                     exec_inst_q  <= head;
                  end
               end
            end
            ST_XFER: begin
               if (mem_ready) begin
                  if (last_beat) begin
                     state_q     <= ST_IDLE;
                     mem_valid_q <= 1'b0;
                     retire_q    <= 1'b1;
                  end else begin
                     beat_q     <= beat_d;
                     mem_addr_q <= mem_addr_d;
                  end
               end
            end
            ST_EXEC: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (exec_done) begin
                  state_q  <= ST_IDLE;
                  retire_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_valid  = mem_valid_q;
   assign mem_addr   = mem_addr_q;
   assign mem_port   = mem_port_q;
   assign exec_valid = exec_valid_q;
   assign exec_inst  = exec_inst_q;
   assign retire     = retire_q;
   assign err        = err_q;
   assign fill_count = count;
   assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Bench for inst_dispatch_queue: scoreboarded beats/issues plus directed scenarios;
// a second instance with three ports exercises the out-of-range port path.
`timescale 1ns/1ps
module tb_inst_dispatch_queue;
   import inst_dispatch_queue_pkg::*;

   localparam int IW = 28;
   localparam int AW = 12;
   localparam int NP = 4;
   localparam int CW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn;

   // ---------------- DUT (4 ports) ----------------
   logic [IW-1:0] inst;
   logic          inst_valid, inst_ready;
   logic [AW-1:0] mem_addr;
   logic [NP-1:0] mem_port;
   logic          mem_valid, mem_ready;
   logic [IW-1:0] exec_inst;
   logic          exec_valid, exec_done;
   logic          busy, retire, err;
   logic [CW-1:0] fill_count;
   state_e        dbg_state;

   inst_dispatch_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(6), .NUM_PORTS(NP), .FIFO_DEPTH(8)) u_dut (
      .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .mem_addr(mem_addr), .mem_port(mem_port), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .exec_inst(exec_inst), .exec_valid(exec_valid), .exec_done(exec_done),
      .busy(busy), .retire(retire), .err(err), .fill_count(fill_count), .dbg_state(dbg_state)
   );

   // ---------------- DUT (3 ports) ----------------
   logic [IW-1:0] inst3;
   logic          inst3_valid, ready3;
   logic [AW-1:0] m3_addr;
   logic [2:0]    m3_port;
   logic          m3_valid, e3_valid, busy3, ret3, err3;
   logic [IW-1:0] e3_inst;
   logic [CW-1:0] fill3;
   state_e        st3;

   inst_dispatch_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(6), .NUM_PORTS(3), .FIFO_DEPTH(8)) u_dut3 (
      .clk(clk), .rstn(rstn), .inst(inst3), .inst_valid(inst3_valid), .inst_ready(ready3),
      .mem_addr(m3_addr), .mem_port(m3_port), .mem_valid(m3_valid), .mem_ready(1'b1),
      .exec_inst(e3_inst), .exec_valid(e3_valid), .exec_done(1'b0),
      .busy(busy3), .retire(ret3), .err(err3), .fill_count(fill3), .dbg_state(st3)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [AW+NP-1:0] exp_q[$];
   logic [IW-1:0]    exp_exec_q[$];
   int exp_ret = 0, got_ret = 0;
   int cyc = 0, beat_seen = 0, first_beat = 0, last_beat = 0, exec_seen = 0;
   int ret3_cnt = 0, m3_seen = 0, e3_seen = 0;
   logic prev_stall = 1'b0, prev_exec = 1'b0;
   logic [AW+NP-1:0] prev_ap = '0;
   int rdy_mode = 0;   // 0 high, 1 toggle, 2 low

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [IW-1:0] mk_inst(input logic [2:0] op, input logic [11:0] addr,
                                            input logic [5:0] len, input logic [1:0] port);
      logic [4:0] rsv;
      rsv = 5'($urandom_range(0, 31));
      return {op, addr, len, port, rsv};
   endfunction

   task automatic model_push(input logic [IW-1:0] w);
      logic [NP-1:0] oh;
      logic [AW-1:0] a;
      oh = '0;
      oh[w[6:5]] = 1'b1;
      if (w[27:25] == 3'b000) begin
         for (int b = 0; b < int'(w[12:7]); b++) begin
            a = w[24:13] + 12'(b);
            exp_q.push_back({oh, a});
         end
      end else begin
         exp_exec_q.push_back(w);
      end
      exp_ret++;
   endtask

   // ---------------- driver tasks (entered at posedge+1) ----------------
   task automatic push(input logic [IW-1:0] w, input int budget, output logic ok);
      ok = 1'b0;
      inst = w;
      inst_valid = 1'b1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (inst_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      inst_valid = 1'b0;
      if (ok) model_push(w);
   endtask

   task automatic push_req(input logic [IW-1:0] w);
      logic ok;
      push(w, 200, ok);
      if (!ok) check("push_timeout", 0, 1);
   endtask

   task automatic push3(input logic [IW-1:0] w);
      logic ok;
      ok = 1'b0;
      inst3 = w;
      inst3_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (ready3) ok = 1'b1;
         @(posedge clk); #1;
      end
      inst3_valid = 1'b0;
      if (!ok) check("push3_timeout", 0, 1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int i;
      i = 0;
      while (i < budget) begin
         @(negedge clk);
         if (!busy) break;
         i++;
      end
      if (i >= budget) check({tag, "_timeout"}, 0, 1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       mem_ready = 1'b1;
         1:       mem_ready = ~mem_ready;
         default: mem_ready = 1'b0;
      endcase
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [AW+NP-1:0] e;
      cyc++;
      if (rstn) begin
         if (mem_valid) begin
            if (prev_stall) check("stall_stable", {mem_port, mem_addr}, prev_ap);
            if (mem_ready) begin
               if (exp_q.size() == 0) check("beat_unexpected", {mem_port, mem_addr}, 0);
               else begin
                  e = exp_q.pop_front();
                  check("beat", {mem_port, mem_addr}, e);
               end
               beat_seen++;
               if (beat_seen == 1) first_beat = cyc;
               last_beat = cyc;
            end
         end
         prev_stall = mem_valid && !mem_ready;
         prev_ap = {mem_port, mem_addr};
         if (exec_valid) begin
            exec_seen++;
            if (prev_exec) check("exec_pulse_width", 2, 1);
            if (exp_exec_q.size() == 0) check("exec_unexpected", exec_inst, 0);
            else check("exec_inst", exec_inst, exp_exec_q.pop_front());
         end
         prev_exec = exec_valid;
         if (retire) got_ret++;
         if (ret3) ret3_cnt++;
         if (m3_valid) m3_seen++;
         if (e3_valid) e3_seen++;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic ok;
      int snap;
      rstn = 1'b0; inst = '0; inst_valid = 1'b0; exec_done = 1'b0;
      inst3 = '0; inst3_valid = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_valid", mem_valid, 0);
      check("rst_exec_valid", exec_valid, 0);
      check("rst_retire", retire, 0);
      check("rst_err", err, 0);
      check("rst_fill", fill_count, 0);
      check("rst_ready", inst_ready, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rstn = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("post_rst_ready", inst_ready, 1);
      check("post_rst_busy", busy, 0);

      // burst with ready held high
      rdy_mode = 0; beat_seen = 0;
      push_req(mk_inst(3'b000, 12'd100, 6'd4, 2'd0));
      wait_idle("s1", 100);
      check("s1_beats", beat_seen, 4);
      check("s1_consecutive", last_beat - first_beat, 3);
      check("s1_retire", got_ret, exp_ret);
      check("s1_left", exp_q.size(), 0);

      // address wrap with stalls
      rdy_mode = 1; beat_seen = 0;
      push_req(mk_inst(3'b000, 12'd4094, 6'd4, 2'd2));
      wait_idle("s2", 100);
      rdy_mode = 0;
      check("s2_beats", beat_seen, 4);
      check("s2_retire", got_ret, exp_ret);
      check("s2_left", exp_q.size(), 0);

      // fill the queue while the dispatcher is stalled
      rdy_mode = 2;
      push_req(mk_inst(3'b000, 12'd10, 6'd2, 2'd1));
      repeat (3) begin @(posedge clk); #1; end
      check("s3_fill0", fill_count, 0);
      for (int i = 0; i < 8; i++) begin
         push(mk_inst(3'b000, 12'(16 * i), 6'd1, 2'(i)), 5, ok);
         check("s3_accept", ok, 1);
         check("s3_fill", fill_count, i + 1);
      end
      push(mk_inst(3'b000, 12'd999, 6'd1, 2'd3), 6, ok);
      check("s3_reject9", ok, 0);
      check("s3_ready_full", inst_ready, 0);
      check("s3_fill8", fill_count, 8);
      rdy_mode = 0;
      wait_idle("s3", 300);
      check("s3_retire", got_ret, exp_ret);
      check("s3_left", exp_q.size(), 0);
      check("s3_fill_end", fill_count, 0);

      // compute issue and exec_done handling
      snap = got_ret;
      exec_done = 1'b1;
      @(posedge clk); #1;
      exec_done = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("s4_stray_done", got_ret, snap);
      exec_seen = 0;
      push_req(mk_inst(3'b100, 12'hABC, 6'd17, 2'd3));
      repeat (20) begin @(posedge clk); #1; end
      check("s4_exec_count", exec_seen, 1);
      check("s4_no_early_retire", got_ret, snap);
      check("s4_wait_state", dbg_state, ST_WAIT);
      check("s4_busy", busy, 1);
      exec_done = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      exec_done = 1'b0;
      @(negedge clk);
      check("s4_retire_pulse", retire, 1);
      wait_idle("s4", 50);
      check("s4_retire", got_ret, exp_ret);
      check("s4_exec_left", exp_exec_q.size(), 0);

      // zero-length on the 4-port instance
      beat_seen = 0;
      push_req(mk_inst(3'b000, 12'd50, 6'd0, 2'd1));
      @(negedge clk);
      check("s5_retire_pop_cycle", retire, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("s5_retire_next", retire, 1);
      wait_idle("s5", 20);
      check("s5_no_beats", beat_seen, 0);
      check("s5_retire", got_ret, exp_ret);
      check("s5_err_clear", err, 0);

      // zero-length then out-of-range port on the 3-port instance
      push3(mk_inst(3'b000, 12'd7, 6'd0, 2'd0));
      repeat (4) begin @(posedge clk); #1; end
      check("s5b_err_before", err3, 0);
      push3(mk_inst(3'b000, 12'd5, 6'd3, 2'd3));
      repeat (4) begin @(posedge clk); #1; end
      check("s5b_err_set", err3, 1);
      push3(mk_inst(3'b101, 12'd5, 6'd3, 2'd3));
      repeat (10) begin @(posedge clk); #1; end
      check("s5b_err_sticky", err3, 1);
      check("s5b_retires", ret3_cnt, 3);
      check("s5b_no_mem_valid", m3_seen, 0);
      check("s5b_no_exec", e3_seen, 0);

      // reset in the middle of a burst with entries still queued
      rdy_mode = 0;
      push_req(mk_inst(3'b000, 12'd200, 6'd8, 2'd3));
      push_req(mk_inst(3'b000, 12'd300, 6'd2, 2'd0));
      push_req(mk_inst(3'b100, 12'd1, 6'd1, 2'd1));
      snap = 0;
      while (snap < 20) begin
         @(negedge clk);
         if (mem_valid && mem_addr == 12'd202) break;
         snap++;
      end
      if (snap >= 20) check("s6_beat2_timeout", 0, 1);
      #1 rstn = 1'b0;
      #1;
      check("s6_mem_valid", mem_valid, 0);
      check("s6_exec_valid", exec_valid, 0);
      check("s6_retire", retire, 0);
      check("s6_fill", fill_count, 0);
      check("s6_ready", inst_ready, 0);
      check("s6_busy", busy, 0);
      check("s6_err3_cleared", err3, 0);
      exp_q.delete();
      exp_exec_q.delete();
      exp_ret -= 3;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      snap = beat_seen;
      repeat (30) begin @(posedge clk); #1; end
      check("s6_no_beats_after", beat_seen, snap);
      check("s6_no_retire", got_ret, exp_ret);
      check("s6_idle", busy, 0);
      check("s6_ready_after", inst_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
